// File: rtl/cash_register.sv
// cash_register: W-bit accumulator with a 7-state Moore controller.
// Items on X are summed into a running total. T shows the sum on Total, and C clears everything.

module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module RippleAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : gBit
    if (i < W - 1) begin : gFull
      FullAdder uFa (
        .a_i   (a_i[i]),
        .b_i   (b_i[i]),
        .cin_i (carry[i]),
        .sum_o (sum_o[i]),
        .cout_o(carry[i+1])
      );
    end else begin : gTop
      // The MSB carry-out is dropped, so sums wrap modulo 2^W.
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    end
  end
endmodule

module cash_register #(
  parameter int W = 16
) (
  input  logic         Clock_i,
  input  logic         Resetn_i,
  input  logic         C_i,
  input  logic         A_i,
  input  logic         T_i,
  input  logic [W-1:0] X_i,
  output logic [W-1:0] Total_o
);
  typedef enum logic [2:0] {
    Init     = 3'd0,
    LoadX    = 3'd1,
    AddX     = 3'd2,
    MoreX    = 3'd3,
    LoadT    = 3'd4,
    DisplayT = 3'd5,
    Clear    = 3'd6
  } stateT;

  stateT        state_q, state_d;
  logic [W-1:0] aReg_q, aReg_d;
  logic [W-1:0] sReg_q, sReg_d;
  logic [W-1:0] tReg_q, tReg_d;
  logic [W-1:0] sumNext;

  RippleAdder #(.W(W)) uAdder (
    .a_i  (sReg_q),
    .b_i  (aReg_q),
    .sum_o(sumNext)
  );

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) state_q <= Init;
    else           state_q <= state_d;
  end

  // Priority in decision states is C > T > A; DisplayT ignores T.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Init, MoreX: begin
        if (C_i)      state_d = Clear;
        else if (T_i) state_d = LoadT;
        else if (A_i) state_d = LoadX;
      end
      LoadX:    state_d = AddX;
      AddX:     state_d = MoreX;
      LoadT:    state_d = DisplayT;
      DisplayT: begin
        if (C_i)              state_d = Clear;
        else if (A_i && !T_i) state_d = LoadX;
      end
      Clear:    state_d = Init;
      default:  state_d = Init;
    endcase
  end

  always_comb begin
    aReg_d = aReg_q;
    sReg_d = sReg_q;
    tReg_d = tReg_q;
    case (state_q)
      LoadX: aReg_d = X_i;
      AddX:  sReg_d = sumNext;
      LoadT: tReg_d = sReg_q;
      Clear: begin
        aReg_d = '0;
        sReg_d = '0;
        tReg_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      aReg_q <= '0;
      sReg_q <= '0;
      tReg_q <= '0;
    end else begin
      aReg_q <= aReg_d;
      sReg_q <= sReg_d;
      tReg_q <= tReg_d;
    end
  end

  assign Total_o = tReg_q;
endmodule

// File: tb/tb_cash_register.sv
// tb_cash_register: directed scenarios followed by random operations.
// A transaction-level model tracks the running sum and the displayed total.

module tb_cash_register;
  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clock;
  logic         resetn;
  logic         cIn, aIn, tIn;
  logic [W-1:0] xIn;
  logic [W-1:0] total;

  int unsigned testsRun  = 0;
  int unsigned failCount = 0;

  int expSum   = 0;
  int expTotal = 0;
  bit inDisplay = 0;

  cash_register #(.W(W)) dut (
    .Clock_i (clock),
    .Resetn_i(resetn),
    .C_i     (cIn),
    .A_i     (aIn),
    .T_i     (tIn),
    .X_i     (xIn),
    .Total_o (total)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: Total=%0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic t, input logic a, input logic [W-1:0] x);
    cIn = c;
    tIn = t;
    aIn = a;
    xIn = x;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic randomControls(input logic [W-1:0] x);
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x);
  endtask

  // Controls are scrambled during states that must advance unconditionally.
  task automatic doAdd(input logic [W-1:0] x, input bit junk);
    applyStimulus(1'b0, 1'b0, 1'b1, x);
    step();
    checkOutput("addLoadX", total, W'(expTotal));
    if (junk) randomControls(x);
    else      applyStimulus(1'b0, 1'b0, 1'b0, x);
    step();
    checkOutput("addAddX", total, W'(expTotal));
    if (junk) randomControls(W'($urandom_range(0, MOD - 1)));
    step();
    checkOutput("addMoreX", total, W'(expTotal));
    expSum    = (expSum + int'(x)) % MOD;
    inDisplay = 0;
  endtask

  task automatic doDisplay(input bit junk);
    if (!inDisplay) begin
      applyStimulus(1'b0, 1'b1, 1'b0, xIn);
      step();
      checkOutput("dispLoadT", total, W'(expTotal));
      if (junk) randomControls(xIn);
      else      applyStimulus(1'b0, 1'b0, 1'b0, xIn);
      step();
      expTotal  = expSum;
      inDisplay = 1;
      checkOutput("dispShow", total, W'(expTotal));
    end else begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), xIn);
      step();
      checkOutput("dispHold1", total, W'(expTotal));
      step();
      checkOutput("dispHold2", total, W'(expTotal));
    end
  endtask

  task automatic doClear(input bit junk);
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), xIn);
    step();
    checkOutput("clrEnter", total, W'(expTotal));
    if (junk) randomControls(xIn);
    else      applyStimulus(1'b0, 1'b0, 1'b0, xIn);
    step();
    expSum    = 0;
    expTotal  = 0;
    inDisplay = 0;
    checkOutput("clrDone", total, W'(expTotal));
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, xIn);
    step();
    checkOutput("idle", total, W'(expTotal));
  endtask

  // Reset is asserted between edges and must act without a clock.
  task automatic doAsyncReset();
    #2;
    resetn = 1'b0;
    #1;
    expSum    = 0;
    expTotal  = 0;
    inDisplay = 0;
    checkOutput("rstAsync", total, W'(expTotal));
    applyStimulus(1'b0, 1'b0, 1'b0, xIn);
    #3;
    resetn = 1'b1;
  endtask

  initial begin
    int r;
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #2;
    checkOutput("rstInit", total, '0);
    #10;
    resetn = 1'b1;

    doAdd(4'd1, 0);
    doAdd(4'd2, 0);
    doAdd(4'd3, 0);
    doDisplay(0);
    doIdle();
    doIdle();

    doClear(0);
    doAdd(4'd5, 0);
    doDisplay(0);

    doClear(0);
    doAdd(4'd1, 0);
    doAdd(4'd2, 0);
    doAdd(4'd3, 0);
    doDisplay(0);
    doAdd(4'd2, 0);
    doDisplay(0);

    doClear(0);
    doAdd(4'd9, 0);
    doAdd(4'd9, 0);
    doDisplay(0);
    doIdle();

    doAdd(4'd7, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, xIn);
    step();
    checkOutput("prioClrEnter", total, W'(expTotal));
    applyStimulus(1'b0, 1'b0, 1'b0, xIn);
    step();
    expSum    = 0;
    expTotal  = 0;
    inDisplay = 0;
    checkOutput("prioClrDone", total, W'(expTotal));
    doAdd(4'd3, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, xIn);
    step();
    checkOutput("prioLoadT", total, W'(expTotal));
    applyStimulus(1'b0, 1'b0, 1'b0, xIn);
    step();
    expTotal  = expSum;
    inDisplay = 1;
    checkOutput("prioShow", total, W'(expTotal));

    doClear(0);
    doAdd(4'd1, 0);
    doAdd(4'd2, 0);
    doDisplay(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
    step();
    checkOutput("midLoadX", total, W'(expTotal));
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd4);
    step();
    checkOutput("midAddX", total, W'(expTotal));
    doAsyncReset();
    doAdd(4'd4, 0);
    doDisplay(0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      doAdd(W'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
      else if (r < 65) doDisplay(1'($urandom_range(0, 1)));
      else if (r < 75) doClear(1'($urandom_range(0, 1)));
      else if (r < 97) doIdle();
      else             doAsyncReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule

// File: doc/cash_register.md
Name: cash_register

Overview:
- Sequential W-bit cash-register accumulator built around a 7-state Moore FSM.
- Loads operand X, adds it to a running sum and repeats while A requests more items.
- On T it copies the sum to a display register that drives Total; on C it clears the sum and the display.
- Standalone datapath-plus-controller block. The adder is a W-bit ripple-carry adder built from full adders, instantiated internally.

Parameters:
- W, default 16 (benches use 4): width of X, the internal registers and Total.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  reset; asynchronous and active-low.
- C  input  1  clear-total request.
- A  input  1  add-next-item request.
- T  input  1  display-total request.
- X  input  W  item value, unsigned.
- Total  output  W  displayed total; registered, driven directly from TREG.

Behaviour:
- Internal registers:
  - AREG (W): latched operand.
  - SREG (W): running sum.
  - TREG (W): display value.
  - Q (3): state.
- State encoding: Init=0, LoadX=1, AddX=2, MoreX=3, LoadT=4, DisplayT=5, Clear=6. Code 7 is illegal and returns to Init on the next edge.
- Reset (Resetn=0, asynchronous): Q=Init; AREG=SREG=TREG=0; Total=0 immediately. Reset dominates every input and state, including mid-operation.
- Input priority in every decision state: C > T > A. Inputs are sampled on the rising edge.
- Init: no register change.
  - C -> Clear; T -> LoadT; A -> LoadX; else stay.
- LoadX: AREG <= X; unconditionally -> AddX. X must be stable at the edge that leaves LoadX.
- AddX: SREG <= SREG + AREG, modulo 2^W. Carry-out is discarded (silent wrap, no overflow flag). Unconditionally -> MoreX.
- MoreX: no register change.
  - C -> Clear; T -> LoadT; A -> LoadX; else stay.
- LoadT: TREG <= SREG; unconditionally -> DisplayT.
- DisplayT: hold TREG; SREG untouched.
  - C -> Clear; A (with T=0) -> LoadX, continuing accumulation; else stay (T held high also stays).
- Clear: SREG <= 0; TREG <= 0; AREG <= 0; unconditionally -> Init.
- Latency:
  - One add cycle costs exactly 3 clocks (LoadX, AddX, MoreX).
  - Total reflects the sum 2 clocks after T is sampled in MoreX (LoadT, then valid in DisplayT).
  - Total goes to 0 at the edge leaving Clear.
- Total changes only at LoadT, at Clear and on reset. It never changes during LoadX, AddX or MoreX, so it is glitch-free and stable.
- A, T and C are level-sensitive, not edge-detected. Holding A high in MoreX re-enters LoadX each pass; one item is added per 3-clock loop.
- Undefined X during LoadX (simulation) propagates into the sum. Benches must drive X before LoadX.

Test Plan:
- Basic sum (W=4): reset; A=1 from Init.
  - X=1 during the 1st LoadX, X=2 during the 2nd, X=3 during the 3rd.
  - In the 3rd MoreX set A=0, T=1.
  - Required: LoadT, then DisplayT with Total=6. Total stays 6 with T=0, C=0.
- Clear: from DisplayT with Total=6, set C=1 for one clock.
  - Required: Clear, then Init, Total=0.
  - A=1, X=5, then T: Total=5 (sum restarted from 0).
- Wrap-around (W=4): add 9 then 9, then T.
  - Required: Total=2 (18 mod 16), no other indication.
- Priority: in MoreX drive C=T=A=1.
  - Required: next state Clear, then Init, Total=0.
  - In MoreX drive T=A=1 (C=0): next state LoadT.
- Async reset mid-operation: assert Resetn=0 between edges while in AddX with SREG=3.
  - Required: Total=0 and Q=Init immediately, without a clock edge.
  - After release, the first add of X=4 followed by T yields Total=4.
- Continue from display: after Total=6 in DisplayT, drive A=1, X=2, then T.
  - Required: Total=8; Total holds 6 throughout LoadX, AddX, MoreX and LoadT, and updates to 8 on entering DisplayT.
